// File: rtl/paced_frame_generator.sv
// paced_frame_generator
//   Ethernet + IPv4 test-frame source for one tester port. Emits a train of
//   frames (sequence number + LFSR payload) on an AXI-Stream master with a
//   programmable inter-frame gap and an optional frame-count limit.
//   Optional feature macro: FRAME_GEN_TIMESTAMP_EN (64-bit cycle timestamp at
//   bytes 38..45 of every frame; when undefined those bytes carry payload).
//   TEST_FRAME_TOS / TEST_FRAME_PROTO may be predefined to override the header
//   TOS and protocol bytes.

`ifndef TEST_FRAME_TOS
`define TEST_FRAME_TOS 8'h00
`endif
`ifndef TEST_FRAME_PROTO
`define TEST_FRAME_PROTO 8'hFD
`endif

module paced_frame_generator #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 3,
  parameter int GAP_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [15:0]             cfg_frame_size,
  input  logic [GAP_WIDTH-1:0]    cfg_gap,
  input  logic [CNT_WIDTH-1:0]    cfg_count,
  input  logic [47:0]             cfg_src_mac,
  input  logic [47:0]             cfg_dst_mac,
  input  logic [31:0]             cfg_src_ip,
  input  logic [31:0]             cfg_dst_ip,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    frames_sent,
  output logic [DATA_WIDTH-1:0]   axis_m_data,
  output logic [DATA_WIDTH/8-1:0] axis_m_keep,
  output logic                    axis_m_last,
  output logic [DATA_WIDTH/8-1:0] axis_m_user,
  output logic [ID_WIDTH-1:0]     axis_m_id,
  output logic                    axis_m_valid,
  input  logic                    axis_m_ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);
  localparam logic [15:0]           BYTES_M1 = 16'(BYTES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = 1;
  localparam logic [BYTES-1:0]      KEEP_ONE = 1;
  localparam logic [15:0]           LFSR_SEED = 16'hACE1;

  if ((DATA_WIDTH % 64) != 0 || DATA_WIDTH < 512) begin : g_width_check
    $error("paced_frame_generator: DATA_WIDTH must be a multiple of 64 and >= 512");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, maximal length, never reaches zero from a non-zero seed
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Frame size saturates to the legal untagged Ethernet range (FCS excluded)
  function automatic logic [15:0] clamp_size(input logic [15:0] s);
    if (s < 16'd60)        return 16'd60;
    else if (s > 16'd1514) return 16'd1514;
    else                   return s;
  endfunction

  function automatic logic [15:0] bswap16(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

`ifdef FRAME_GEN_TIMESTAMP_EN
  function automatic logic [63:0] bswap64(input logic [63:0] x);
    return {bswap32(x[31:0]), bswap32(x[63:32])};
  endfunction
`endif

  // One's-complement header checksum; flags/fragment word and checksum field are zero
  function automatic logic [15:0] ip_csum(input logic [15:0] len, input logic [15:0] id,
                                          input logic [31:0] sip, input logic [31:0] dip);
    logic [19:0] s;
    s = {4'h0, 8'h45, `TEST_FRAME_TOS} + {4'h0, len} + {4'h0, id} +
        {4'h0, 8'd64, `TEST_FRAME_PROTO} +
        {4'h0, sip[31:16]} + {4'h0, sip[15:0]} + {4'h0, dip[31:16]} + {4'h0, dip[15:0]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    return ~s[15:0];
  endfunction

  state_t                state;
  logic                  stop_q;
  logic                  done_q;
  logic [CNT_WIDTH-1:0]  frames_q;
  logic [CNT_WIDTH-1:0]  seq_q;
  logic [15:0]           beat_idx;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [15:0]           id_lfsr;

  // Job configuration and per-frame header state (not reset; gated by valid at the output)
  logic [15:0]           size_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [47:0]           src_mac_q;
  logic [47:0]           dst_mac_q;
  logic [31:0]           src_ip_q;
  logic [31:0]           dst_ip_q;
  logic [15:0]           id_q;
  logic [15:0]           pay_q;

  logic                  valid;
  logic                  hs;
  logic                  last_beat;
  logic                  end_frame;
  logic                  load_hdr;
  logic [15:0]           n_beats;
  logic [15:0]           ip_len;
  logic [15:0]           csum;
  logic [CNT_WIDTH-1:0]  frames_next;
  logic [LOG2B-1:0]      rem;
  logic [BYTES-1:0]      last_keep;
  logic [303:0]          hdr;
  logic [DATA_WIDTH-1:0] frame;

  assign valid       = (state == SEND);
  assign hs          = valid && axis_m_ready;
  assign n_beats     = (size_q + BYTES_M1) >> LOG2B;
  assign last_beat   = (beat_idx == n_beats - 16'd1);
  assign frames_next = frames_q + CNT_ONE;
  assign end_frame   = stop_q || stop || ((count_q != '0) && (frames_next == count_q));
  assign ip_len      = size_q - 16'd14;
  assign csum        = ip_csum(ip_len, id_q, src_ip_q, dst_ip_q);
  assign rem         = size_q[LOG2B-1:0];
  assign last_keep   = (rem == '0) ? '1 : ((KEEP_ONE << rem) - KEEP_ONE);

  // A fresh header is loaded on start, on a back-to-back frame boundary, and at gap expiry
  assign load_hdr = ((state == IDLE) && start) ||
                    ((state == SEND) && hs && last_beat && !end_frame && (gap_q == '0)) ||
                    ((state == GAP) && !stop && (gap_cnt == GAP_ONE));

  // Header bytes 0..37 in wire order, byte 0 in the least significant position
  assign hdr = {bswap32(32'(seq_q)), bswap32(dst_ip_q), bswap32(src_ip_q), bswap16(csum),
                `TEST_FRAME_PROTO, 8'd64, 16'h0000, bswap16(id_q), bswap16(ip_len),
                `TEST_FRAME_TOS, 8'h45, 8'h00, 8'h08, src_mac_q, dst_mac_q};

`ifdef FRAME_GEN_TIMESTAMP_EN
  logic [63:0] ts_cnt;
  logic [63:0] ts_q;

  // Free-running cycle counter, captured when each frame header is loaded
  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 64'd1;
    if (load_hdr) ts_q <= ts_cnt;
  end
`endif

  // Beat contents: payload LFSR replicated, with the header overlaid on beat 0
  always_comb begin
    frame = {(BYTES/2){pay_q}};
    if (beat_idx == 16'd0) begin
      frame[303:0] = hdr;
`ifdef FRAME_GEN_TIMESTAMP_EN
      frame[367:304] = bswap64(ts_q);
`endif
    end
  end

  // Free-running LFSR that supplies the IPv4 identification of each frame
  always_ff @(posedge clk) begin
    if (rst) id_lfsr <= LFSR_SEED;
    else     id_lfsr <= lfsr_step(id_lfsr);
  end

  // Control FSM: IDLE -> SEND -> (SEND | GAP | IDLE), GAP -> SEND | IDLE
  always_ff @(posedge clk) begin
    if (load_hdr) begin
      id_q  <= id_lfsr;
      pay_q <= id_lfsr;
    end else if (hs && !last_beat) begin
      pay_q <= lfsr_step(pay_q);
    end
    if (rst) begin
      state    <= IDLE;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= '0;
      seq_q    <= '0;
      beat_idx <= '0;
      gap_cnt  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            size_q    <= clamp_size(cfg_frame_size);
            gap_q     <= cfg_gap;
            count_q   <= cfg_count;
            src_mac_q <= cfg_src_mac;
            dst_mac_q <= cfg_dst_mac;
            src_ip_q  <= cfg_src_ip;
            dst_ip_q  <= cfg_dst_ip;
            stop_q    <= stop;
            frames_q  <= '0;
            seq_q     <= '0;
            beat_idx  <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (stop) stop_q <= 1'b1;
          if (hs) begin
            if (!last_beat) begin
              beat_idx <= beat_idx + 16'd1;
            end else begin
              frames_q <= frames_next;
              seq_q    <= seq_q + CNT_ONE;
              beat_idx <= '0;
              if (end_frame) begin
                state  <= IDLE;
                done_q <= 1'b1;
                stop_q <= 1'b0;
              end else if (gap_q != '0) begin
                state   <= GAP;
                gap_cnt <= gap_q;
              end
            end
          end
        end
        GAP: begin
          if (stop) begin
            state  <= IDLE;
            done_q <= 1'b1;
            stop_q <= 1'b0;
          end else if (gap_cnt == GAP_ONE) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign frames_sent  = frames_q;
  assign axis_m_valid = valid;
  assign axis_m_data  = valid ? frame : '0;
  assign axis_m_keep  = valid ? (last_beat ? last_keep : '1) : '0;
  assign axis_m_last  = valid && last_beat;
  assign axis_m_user  = '0;
  assign axis_m_id    = '0;

endmodule
